// File: rtl/pd_pkg.sv
// Shared definitions for the pattern-detector path.
// Symbols, serializer FSM encoding and detector one-hot states.
package pd_pkg;

  localparam logic B = 1'b0;
  localparam logic C = 1'b1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_e;

  localparam logic [4:0] DET_S0 = 5'b00001;
  localparam logic [4:0] DET_S1 = 5'b00010;
  localparam logic [4:0] DET_S2 = 5'b00100;
  localparam logic [4:0] DET_S3 = 5'b01000;
  localparam logic [4:0] DET_S4 = 5'b10000;

endpackage

// File: rtl/pd_word_serializer.sv
// Word-to-bit serializer feeding the pattern detector.
// One-entry holding register keeps consecutive words gap-free.
module pd_word_serializer
  import pd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             en_i,
  output logic             valid_o,
  output logic             data_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;
  logic             valid_q, valid_d;
  logic             data_q, data_d;
  logic             accept;
  logic             next_bit;

  assign accept   = wr_valid_i & ~hold_full_q;
  assign next_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    // accept needs an empty hold, drain needs a full one
    if (accept) begin
      hold_d      = wr_data_i;
      hold_full_d = 1'b1;
    end
    if (en_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            cnt_d       = CNT_FULL;
            hold_full_d = 1'b0;
            state_d     = S_SHIFT;
          end
        end
        S_SHIFT: begin
          valid_d = 1'b1;
          data_d  = next_bit;
          shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            if (hold_full_q) begin
              shift_d     = hold_q;
              cnt_d       = CNT_FULL;
              hold_full_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= B;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  assign wr_ready_o = ~hold_full_q;
  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign busy_o     = hold_full_q | (state_q == S_SHIFT);

endmodule
